// File: rtl/mux4_rr_arbiter_if.sv
// Shared-channel bundle for mux4_rr_arbiter: four requester lanes in, one muxed lane out.
// master = requesters/consumer side, slave = the arbiter.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [3:0]       last;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic             y_ready;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic [1:0]       sel;
  logic [3:0]       gnt;
  logic [3:0]       ack;

  modport master (
    output req, last, din0, din1, din2, din3, y_ready,
    input  y, y_valid, sel, gnt, ack
  );

  modport slave (
    input  req, last, din0, din1, din2, din3, y_ready,
    output y, y_valid, sel, gnt, ack
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 channel arbiter with registered grant/select and a combinational data mux.
// Optional per-grant beat limit enabled by defining MUX4_ARB_BURST_LIMIT_EN.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("mux4_rr_arbiter: MAX_BURST must be at least 1");
  end

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] y_mux;
  logic             busy;
  logic             y_vld;
  logic             xfer;
  logic             limit_hit;
  logic             release_gnt;
  logic [2:0]       pick_ptr;
  logic [2:0]       pick_sel;

  // Returns {found, index}; lowest offset from start wins.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + i[1:0];
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    y_mux = '0;
    case (sel_q)
      2'd0:    y_mux = bus.din0;
      2'd1:    y_mux = bus.din1;
      2'd2:    y_mux = bus.din2;
      default: y_mux = bus.din3;
    endcase
  end

  assign busy        = (state_q == BUSY);
  assign y_vld       = busy & bus.req[sel_q];
  assign xfer        = y_vld & bus.y_ready;
  assign bus.y       = busy ? y_mux : '0;
  assign bus.y_valid = y_vld;
  assign bus.sel     = sel_q;
  assign bus.gnt     = gnt_q;
  assign bus.ack     = gnt_q & {4{xfer}};

  assign pick_ptr = pick(bus.req, ptr_q + 2'd1);
  assign pick_sel = pick(bus.req, sel_q + 2'd1);

`ifdef MUX4_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign limit_hit = xfer && ((cnt_q + 1'b1) == CW'(MAX_BURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Counter clears whenever a grant is (re)issued or dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || release_gnt) cnt_d = '0;
    else if (xfer)                      cnt_d = cnt_q + 1'b1;
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign release_gnt = busy & ((xfer & bus.last[sel_q]) | ~bus.req[sel_q] | limit_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Releasing requester is searched last, so it only re-wins when alone.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_ptr[2]) begin
          state_d = BUSY;
          sel_d   = pick_ptr[1:0];
          gnt_d   = 4'b0001 << pick_ptr[1:0];
          ptr_d   = pick_ptr[1:0];
        end
      end
      default: begin
        if (release_gnt) begin
          if (pick_sel[2]) begin
            sel_d = pick_sel[1:0];
            gnt_d = 4'b0001 << pick_sel[1:0];
            ptr_d = pick_sel[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, single beat, rotation, stalls, abort,
// burst limit (expectations follow MUX4_ARB_BURST_LIMIT_EN) and mid-burst reset.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mux4_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.req     = 4'b0000;
    bus.last    = 4'b0000;
    bus.din0    = 8'h00;
    bus.din1    = 8'h00;
    bus.din2    = 8'h00;
    bus.din3    = 8'h00;
    bus.y_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.din0 = 8'h5A;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
    n_checks++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", bus.sel); end
    n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_yvalid got %b want 0", bus.y_valid); end
    n_checks++; if (bus.y !== 8'h00) begin n_fail++; $display("FAIL reset_y got %h want 00", bus.y); end
    n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req = 4'b0001; bus.last = 4'b0001; bus.din0 = 8'hA5; bus.y_ready = 1'b1;
    #1;
    n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL single_pregrant_yvalid got %b want 0", bus.y_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt got %b want 0001", bus.gnt); end
    n_checks++; if (bus.y !== 8'hA5) begin n_fail++; $display("FAIL single_y got %h want a5", bus.y); end
    n_checks++; if (bus.y_valid !== 1'b1) begin n_fail++; $display("FAIL single_yvalid got %b want 1", bus.y_valid); end
    n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got %b want 0001", bus.ack); end
    @(negedge clk);
    bus.req = 4'b0000;
    #1;
    n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_after got %b want 0000", bus.ack); end
    @(negedge clk); #1;
    n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_idle_gnt got %b want 0000", bus.gnt); end
    n_checks++; if (bus.y !== 8'h00) begin n_fail++; $display("FAIL single_idle_y got %h want 00", bus.y); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_y;
    do_reset();
    bus.req = 4'b1111; bus.last = 4'b1111; bus.y_ready = 1'b1;
    bus.din0 = 8'h10; bus.din1 = 8'h11; bus.din2 = 8'h12; bus.din3 = 8'h13;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      exp_g = 4'b0001 << (c % 4);
      exp_y = 8'h10 + 8'(c % 4);
      n_checks++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, bus.gnt, exp_g); end
      n_checks++; if (bus.sel !== 2'(c % 4)) begin n_fail++; $display("FAIL rr_sel cycle %0d got %0d want %0d", c, bus.sel, c % 4); end
      n_checks++; if (bus.ack !== exp_g) begin n_fail++; $display("FAIL rr_ack cycle %0d got %b want %b", c, bus.ack, exp_g); end
      n_checks++; if (bus.y !== exp_y) begin n_fail++; $display("FAIL rr_y cycle %0d got %h want %h", c, bus.y, exp_y); end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_stall();
    logic [4:0] rdy_pat;
    int         beat;
    int         acks;
    logic [3:0] exp_ack;
    rdy_pat = 5'b10101;
    beat = 0;
    acks = 0;
    do_reset();
    bus.req = 4'b0100; bus.last = 4'b0000; bus.din2 = 8'h20;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.din2    = 8'h20 + 8'(beat);
      bus.last    = (beat == 2) ? 4'b0100 : 4'b0000;
      bus.y_ready = rdy_pat[4 - c];
      #1;
      exp_ack = bus.y_ready ? 4'b0100 : 4'b0000;
      n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL stall_gnt cycle %0d got %b want 0100", c, bus.gnt); end
      n_checks++; if (bus.y !== 8'h20 + 8'(beat)) begin n_fail++; $display("FAIL stall_y cycle %0d got %h want %h", c, bus.y, 8'h20 + 8'(beat)); end
      n_checks++; if (bus.ack !== exp_ack) begin n_fail++; $display("FAIL stall_ack cycle %0d got %b want %b", c, bus.ack, exp_ack); end
      if (bus.ack[2]) acks++;
      if (rdy_pat[4 - c]) beat++;
    end
    n_checks++; if (acks != 3) begin n_fail++; $display("FAIL stall_ack_count got %0d want 3", acks); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    bus.req = 4'b0010; bus.last = 4'b0000; bus.y_ready = 1'b1;
    bus.din1 = 8'h31; bus.din3 = 8'h33;
    @(negedge clk);
    bus.req = 4'b1010;
    #1;
    n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_gnt1 got %b want 0010", bus.gnt); end
    n_checks++; if (bus.ack !== 4'b0010) begin n_fail++; $display("FAIL abort_beat1_ack got %b want 0010", bus.ack); end
    @(negedge clk);
    bus.req = 4'b1000;
    #1;
    n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL abort_drop_ack got %b want 0000", bus.ack); end
    n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL abort_drop_yvalid got %b want 0", bus.y_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL abort_gnt3 got %b want 1000", bus.gnt); end
    n_checks++; if (bus.sel !== 2'd3) begin n_fail++; $display("FAIL abort_sel got %0d want 3", bus.sel); end
    n_checks++; if (bus.y !== 8'h33) begin n_fail++; $display("FAIL abort_y got %h want 33", bus.y); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_burst_limit();
    int         seq [7];
    int         left0;
    int         left1;
    int         b0;
    logic [3:0] exp_g;
`ifdef MUX4_ARB_BURST_LIMIT_EN
    seq = '{0, 0, 0, 0, 1, 0, 0};
`else
    seq = '{0, 0, 0, 0, 0, 0, 1};
`endif
    left0 = 6;
    left1 = 1;
    b0 = 0;
    do_reset();
    bus.req = 4'b0011; bus.last = 4'b0010; bus.y_ready = 1'b1;
    bus.din0 = 8'h40; bus.din1 = 8'h51;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus.req  = {2'b00, left1 > 0, left0 > 0};
      bus.last = {2'b00, 1'b1, left0 == 1};
      bus.din0 = 8'h40 + 8'(b0);
      #1;
      exp_g = 4'b0001 << seq[c];
      n_checks++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL burst_gnt cycle %0d got %b want %b", c, bus.gnt, exp_g); end
      n_checks++; if (bus.ack !== exp_g) begin n_fail++; $display("FAIL burst_ack cycle %0d got %b want %b", c, bus.ack, exp_g); end
      if (seq[c] == 0) begin
        n_checks++; if (bus.y !== 8'h40 + 8'(b0)) begin n_fail++; $display("FAIL burst_y0 cycle %0d got %h want %h", c, bus.y, 8'h40 + 8'(b0)); end
        left0--; b0++;
      end else begin
        n_checks++; if (bus.y !== 8'h51) begin n_fail++; $display("FAIL burst_y1 cycle %0d got %h want 51", c, bus.y); end
        left1--;
      end
    end
    @(negedge clk);
    bus.req = 4'b0000;
    #1;
    n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL burst_end_yvalid got %b want 0", bus.y_valid); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b1111; bus.last = 4'b0000; bus.y_ready = 1'b1;
    bus.din0 = 8'h60;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_pre_gnt got %b want 0001", bus.gnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_gnt got %b want 0000", bus.gnt); end
    n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_yvalid got %b want 0", bus.y_valid); end
    n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack got %b want 0000", bus.ack); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_regrant got %b want 0001", bus.gnt); end
    n_checks++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL rstmid_sel got %0d want 0", bus.sel); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_abort();
    test_burst_limit();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for a shared 4:1 multiplexed channel. Four requesters present valid/data/last; the block grants one at a time, drives the mux select, forwards the granted data onto a single output with a valid/ready handshake, and rotates priority after each burst. Sits in front of any consumer that must share one datapath among four sources.

## Interface
- WIDTH, 8, data width of each input and of the output
- MAX_BURST, 4, beats per grant before forced rotation (only with burst limit compiled in); must be ≥1
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  per-requester valid; bit i belongs to din_i
- last  input  4  per-requester end-of-burst marker, sampled with a transfer
- din0..din3  input  WIDTH each  requester data
- y_ready  input  1  downstream ready
- y  output  WIDTH  forwarded data
- y_valid  output  1  output valid
- sel  output  2  registered mux select (index of granted requester)
- gnt  output  4  registered one-hot grant
- ack  output  4  combinational, gnt & {4{y_valid & y_ready}}: beat accepted

## Operation
- States: IDLE (no grant), BUSY (one grant held).
- Priority pointer ptr (2 bits) = index of last winner; search order ptr+1, ptr+2, ptr+3, ptr (mod 4). First requester with req high wins.
- IDLE: if any req bit high, register winner into sel, set gnt = 1<<winner, ptr = winner, count = 0, go BUSY. Else stay.
- BUSY: y = din[sel] (combinational mux), y_valid = req[sel]. Transfer = y_valid & y_ready.
- Release conditions in BUSY: (a) transfer with last[sel]=1; (b) req[sel]=0 (abort, no transfer); (c) burst limit hit (see Configuration).
- On release: re-arbitrate in the same cycle over current req with search starting at sel+1; next-cycle grant goes to winner (count cleared), or to IDLE with gnt=0 if no other req and the releasing requester is not requesting. Releasing requester may win again only if no other req is high.
- Not BUSY: y = 0, y_valid = 0, ack = 0.
- Simultaneous requests: rotating order only; no requester is granted twice in a row while another is requesting at release.

## Timing
- Reset values: state IDLE, sel=0, gnt=0, ptr=3 (requester 0 highest priority first), count=0, y=0, y_valid=0, ack=0.
- Reset asserted mid-burst: all of the above immediately (asynchronous); no partial beat acknowledged after the edge.
- Grant latency: req rising sampled at edge N in IDLE -> gnt/sel valid after edge N, y_valid same cycle; one cycle from req to first possible transfer.
- Back-to-back handoff: release at edge N -> new gnt after edge N, zero bubble cycles between bursts of different requesters.
- y_ready low stalls: gnt, sel, count hold; y follows din[sel] live; requester must hold din/last stable while req high and ack low.
- ack asserted only in the cycle a beat is taken; last is ignored when ack is 0.

## Configuration
- MUX4_ARB_BURST_LIMIT_EN defined: count (width ceil(log2(MAX_BURST+1))) increments per transfer; transfer that makes count == MAX_BURST releases the grant even if last=0; requester re-competes in rotation for the rest of its burst.
- Not defined: no counter; grant held until last or abort; MAX_BURST ignored.

## Test plan
- Reset then req=4'b0001, last=4'b0001, din0=8'hA5, y_ready=1 -> gnt=0001 one cycle later, y=8'hA5, y_valid=1, ack=0001 for one cycle, then IDLE (gnt=0).
- req=4'b1111 held, every beat last=1 -> grants cycle 0,1,2,3,0,... with one grant per cycle, sel matching, no bubbles.
- Requester 2 burst of 3 beats (last on 3rd), y_ready toggled 1,0,1,0,1 -> exactly 3 acks, gnt=0100 throughout, din2 values appear on y in order.
- Requester 1 granted, drops req after 1 beat without last, req[3]=1 -> release next edge, gnt=1000, no ack for requester 1 after drop.
- With MUX4_ARB_BURST_LIMIT_EN, MAX_BURST=4, req=4'b0011, requester 0 sends 6 beats last only on 6th -> 4 beats, grant to 1 for its burst, then back to 0 for remaining 2; without macro -> all 6 beats contiguous.
- Assert rst for one cycle mid-burst with req=4'b1111 -> gnt=0, y_valid=0 immediately; after release requester 0 granted first.
